// File: rtl/timestamp_shifter_if.sv
// Bus bundle between the timestamp source / JTAG TDR mux and timestamp_shifter.
// master drives the fields and JTAG controls; slave is the shifter itself.
interface timestamp_shifter_if;
    logic [6:0] ts_revision;
    logic [3:0] ts_subrevision;
    logic [6:0] ts_year;
    logic [3:0] ts_month;
    logic [4:0] ts_day;
    logic [4:0] ts_hour;
    logic [5:0] ts_minute;
    logic       capture_dr;
    logic       shift_dr;
    logic       tdi;
    logic       tdo;
    logic       busy;
    logic       frame_done;
    logic [5:0] bit_count;
    logic       field_err;

    modport master (
        output ts_revision, ts_subrevision, ts_year, ts_month, ts_day, ts_hour, ts_minute,
        output capture_dr, shift_dr, tdi,
        input  tdo, busy, frame_done, bit_count, field_err
    );

    modport slave (
        input  ts_revision, ts_subrevision, ts_year, ts_month, ts_day, ts_hour, ts_minute,
        input  capture_dr, shift_dr, tdi,
        output tdo, busy, frame_done, bit_count, field_err
    );
endinterface

// File: rtl/timestamp_shifter.sv
// Build-timestamp serial data register for the virtual-JTAG readout path.
// Define TIMESTAMP_SHIFTER_PARITY_EN to append an even-parity bit (39-bit frame).
module timestamp_shifter #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    timestamp_shifter_if.slave   bus
);

`ifdef TIMESTAMP_SHIFTER_PARITY_EN
    localparam int FRAME_W = 39;
`else
    localparam int FRAME_W = 38;
`endif
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_W - 1);
    localparam logic [5:0] FULL_BITS = 6'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   sr_q, sr_d;
    logic [5:0]           bit_count_q, bit_count_d;
    logic                 field_err_q, field_err_d;
    logic                 frame_done_q, frame_done_d;

    logic [37:0]          frame_raw;
    logic [FRAME_W-1:0]   frame;
    logic                 range_err;

    always_comb begin
        frame_raw = {bus.ts_minute, bus.ts_hour, bus.ts_day, bus.ts_month,
                     bus.ts_year, bus.ts_subrevision, bus.ts_revision};
`ifdef TIMESTAMP_SHIFTER_PARITY_EN
        frame = {^frame_raw, frame_raw};
`else
        frame = frame_raw;
`endif
        range_err = (bus.ts_month == 4'd0) || (bus.ts_month > 4'd12) ||
                    (bus.ts_day == 5'd0)   || (bus.ts_hour > 5'd23)  ||
                    (bus.ts_minute > 6'd59);
    end

    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_count_d  = bit_count_q;
        field_err_d  = field_err_q;
        frame_done_d = 1'b0;

        if (bus.capture_dr) begin
            sr_d        = frame;
            bit_count_d = 6'd0;
            state_d     = LOADED;
            field_err_d = range_err;
        end else if (bus.shift_dr) begin
            if (LSB_FIRST) sr_d = {bus.tdi, sr_q[FRAME_W-1:1]};
            else           sr_d = {sr_q[FRAME_W-2:0], bus.tdi};

            // IDLE and DONE keep passing data through but never count or pulse.
            if (state_q == LOADED || state_q == SHIFT) begin
                bit_count_d = bit_count_q + 6'd1;
                state_d     = SHIFT;
                if (bit_count_q == LAST_BIT) begin
                    bit_count_d  = FULL_BITS;
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_count_q  <= 6'd0;
            field_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_count_q  <= bit_count_d;
            field_err_q  <= field_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.tdo        = LSB_FIRST ? sr_q[0] : sr_q[FRAME_W-1];
    assign bus.busy       = (state_q == LOADED) || (state_q == SHIFT);
    assign bus.bit_count  = bit_count_q;
    assign bus.field_err  = field_err_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_timestamp_shifter.sv
// Scoreboard bench for timestamp_shifter: one LSB-first and one MSB-first instance
// share stimulus; expectations are queued per cycle and compared after the edge.
`timescale 1ns/1ps
module tb_timestamp_shifter;

`ifdef TIMESTAMP_SHIFTER_PARITY_EN
    localparam int FW = 39;
`else
    localparam int FW = 38;
`endif

    typedef enum {S_TDO_L, S_TDO_M, S_BC, S_BUSY, S_DONE, S_ERR} sel_e;
    typedef struct {
        string      tag;
        sel_e       sel;
        logic [7:0] exp;
    } exp_t;
    typedef struct packed {
        logic [6:0] rev;
        logic [3:0] sub;
        logic [6:0] year;
        logic [3:0] month;
        logic [4:0] day;
        logic [4:0] hour;
        logic [5:0] minute;
    } ts_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    timestamp_shifter_if if_l ();
    timestamp_shifter_if if_m ();

    timestamp_shifter #(.LSB_FIRST(1'b1)) dut_l (.clk(clk), .reset_n(reset_n), .bus(if_l));
    timestamp_shifter #(.LSB_FIRST(1'b0)) dut_m (.clk(clk), .reset_n(reset_n), .bus(if_m));

    exp_t          sb[$];
    logic          tdi_hist[$];
    logic [FW-1:0] cur_frame;
    logic          cur_err;
    int            k;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input ts_t t);
        logic [37:0] raw;
        raw = {t.minute, t.hour, t.day, t.month, t.year, t.sub, t.rev};
`ifdef TIMESTAMP_SHIFTER_PARITY_EN
        return {^raw, raw};
`else
        return raw;
`endif
    endfunction

    function automatic logic exp_err(input ts_t t);
        return (t.month == 0) || (t.month > 12) || (t.day == 0) ||
               (t.hour > 23) || (t.minute > 59);
    endfunction

    // Bit on tdo after k shifts since capture: frame bits first, then tdi history.
    function automatic logic tdo_exp(input bit lsb);
        if (k < FW) return lsb ? cur_frame[k] : cur_frame[FW-1-k];
        return tdi_hist[k-FW];
    endfunction

    task automatic set_in(input ts_t t, input logic cap, input logic shf, input logic d);
        {if_l.ts_revision, if_l.ts_subrevision, if_l.ts_year, if_l.ts_month,
         if_l.ts_day, if_l.ts_hour, if_l.ts_minute} = t;
        {if_m.ts_revision, if_m.ts_subrevision, if_m.ts_year, if_m.ts_month,
         if_m.ts_day, if_m.ts_hour, if_m.ts_minute} = t;
        if_l.capture_dr = cap; if_m.capture_dr = cap;
        if_l.shift_dr   = shf; if_m.shift_dr   = shf;
        if_l.tdi        = d;   if_m.tdi        = d;
    endtask

    task automatic push(input string tag, input sel_e sel, input logic [7:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag, input logic busy_e, input logic done_e);
        push({tag, ".tdo_lsb"}, S_TDO_L, {7'd0, tdo_exp(1'b1)});
        push({tag, ".tdo_msb"}, S_TDO_M, {7'd0, tdo_exp(1'b0)});
        push({tag, ".bit_count"}, S_BC, 8'((k >= FW) ? FW : k));
        push({tag, ".busy"}, S_BUSY, {7'd0, busy_e});
        push({tag, ".frame_done"}, S_DONE, {7'd0, done_e});
        push({tag, ".field_err"}, S_ERR, {7'd0, cur_err});
    endtask

    task automatic push_zero(input string tag);
        push({tag, ".tdo_lsb"}, S_TDO_L, 8'd0);
        push({tag, ".tdo_msb"}, S_TDO_M, 8'd0);
        push({tag, ".bit_count"}, S_BC, 8'd0);
        push({tag, ".busy"}, S_BUSY, 8'd0);
        push({tag, ".frame_done"}, S_DONE, 8'd0);
        push({tag, ".field_err"}, S_ERR, 8'd0);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_TDO_L: act = {7'd0, if_l.tdo};
                S_TDO_M: act = {7'd0, if_m.tdo};
                S_BC:    act = {2'd0, if_l.bit_count};
                S_BUSY:  act = {7'd0, if_l.busy};
                S_DONE:  act = {7'd0, if_l.frame_done};
                default: act = {7'd0, if_l.field_err};
            endcase
            check(e.tag, act, e.exp);
            // The MSB-first instance must agree on all non-serial outputs.
            if (e.sel == S_BC)   check({e.tag, "_m"}, {2'd0, if_m.bit_count}, e.exp);
            if (e.sel == S_DONE) check({e.tag, "_m"}, {7'd0, if_m.frame_done}, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drain();
    endtask

    function automatic ts_t rand_ts();
        logic [63:0] rr;
        rr = {$urandom(), $urandom()};
        return rr[37:0];
    endfunction

    task automatic do_capture(input ts_t t, input logic with_shift, input string tag);
        set_in(t, 1'b1, with_shift, 1'b1);
        cur_frame = mk_frame(t);
        cur_err   = exp_err(t);
        k = 0;
        tdi_hist.delete();
        push_state(tag, 1'b1, 1'b0);
        step();
    endtask

    // Field inputs are scrambled while shifting; they must not affect the frame.
    task automatic do_shift(input int n, input string tag);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom());
            set_in(rand_ts(), 1'b0, 1'b1, b);
            tdi_hist.push_back(b);
            k++;
            push_state($sformatf("%s[%0d]", tag, k), k < FW, k == FW);
            step();
        end
    endtask

    task automatic do_idle(input string tag);
        set_in(rand_ts(), 1'b0, 1'b0, 1'b1);
        push_state(tag, k < FW, 1'b0);
        step();
    endtask

    ts_t v1, v_bad, v_max;

    initial begin
        v1 = '{rev: 7'h46, sub: 4'd2, year: 7'h17, month: 4'd1,
               day: 5'h11, hour: 5'h12, minute: 6'h0C};
        v_max = '{rev: 7'h7F, sub: 4'hF, year: 7'h7F, month: 4'd12,
                  day: 5'd31, hour: 5'd23, minute: 6'd59};

        // Reset with shift asserted: reset must win.
        set_in(v1, 1'b0, 1'b1, 1'b1);
        reset_n = 1'b0;
        push_zero("reset");
        step();
        reset_n = 1'b1;

        // Capture, full frame out (LSB and MSB order), then DONE passthrough.
        do_capture(v1, 1'b0, "cap1");
        do_shift(FW, "shift1");
        do_shift(FW + 3, "passthru");
        do_idle("hold_done");

        // Range-check boundaries.
        v_bad = v1; v_bad.month = 4'd13;
        do_capture(v_bad, 1'b0, "err_month13");
        do_capture(v_max, 1'b0, "ok_max");
        v_bad = v1; v_bad.month = 4'd0;
        do_capture(v_bad, 1'b0, "err_month0");
        v_bad = v1; v_bad.day = 5'd0;
        do_capture(v_bad, 1'b0, "err_day0");
        v_bad = v1; v_bad.hour = 5'd24;
        do_capture(v_bad, 1'b0, "err_hour24");
        v_bad = v1; v_bad.minute = 6'd60;
        do_capture(v_bad, 1'b0, "err_min60");

        // Capture beats a simultaneous shift; then hold and shift from the fresh frame.
        do_capture(v_max, 1'b1, "cap_and_shift");
        do_idle("hold_loaded");
        do_shift(3, "after_cs");

        // Reset in the middle of a shift, then a clean restart.
        do_capture(v1, 1'b0, "cap2");
        do_shift(10, "shift2");
        set_in(v1, 1'b0, 1'b1, 1'b1);
        reset_n = 1'b0;
        push_zero("mid_reset");
        step();
        reset_n = 1'b1;
        set_in(v1, 1'b0, 1'b0, 1'b1);
        push_zero("post_reset_idle");
        step();
        do_capture(rand_ts(), 1'b0, "cap3");
        do_shift(FW, "shift3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

endmodule
